reg_wr_arb: RTL
===============

REG_WR_ARB -- requirements
Module: reg_wr_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, legal range 2..8.
REQ-002 Parameter DATA_W, default 8: width of the shared register.
REQ-003 Parameter MAX_LOCK, default 4: maximum consecutive writes per grant, legal range 1..16.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req  in  NUM_REQ  per-requester write request.
REQ-007 lock  in  NUM_REQ  per-requester request to keep the grant for further writes.
REQ-008 wdata  in  NUM_REQ*DATA_W  write data; requester i uses bits [i*DATA_W +: DATA_W].
REQ-009 gnt  out  NUM_REQ  registered one-hot grant, all-zero when idle.
REQ-010 owner  out  $clog2(NUM_REQ)  registered index of the current grantee; holds its last value when idle.
REQ-011 q  out  DATA_W  shared register contents.
REQ-012 q_valid  out  1  one-cycle pulse in the cycle after each write to q.

Function
REQ-013 FSM SHALL have two states, IDLE and OWN; gnt is non-zero only in OWN.
REQ-014 IDLE: if any req bit is high at an edge, SHALL pick the winner w, move to OWN, and set gnt=1<<w, owner=w, lock_cnt=0.
REQ-015 Winner: first set req bit scanning upward from rr_ptr, wrapping from NUM_REQ-1 to 0.
REQ-016 OWN: at each edge with req[w]=1, SHALL write q<=wdata slice w and assert q_valid in the following cycle.
REQ-017 OWN stays when req[w]=1, lock[w]=1 and lock_cnt<MAX_LOCK-1; lock_cnt SHALL increment by 1.
REQ-018 Otherwise the grant SHALL be released at that edge and rr_ptr set to (w+1) mod NUM_REQ.
REQ-019 On release with other req bits high, the next winner SHALL be granted at the same edge (back-to-back, no idle cycle), using the updated rr_ptr; otherwise go to IDLE.
REQ-020 If req[w]=0 while in OWN: no write, q_valid=0 next cycle, release per REQ-018/019.
REQ-021 A grant SHALL yield at most MAX_LOCK writes; with MAX_LOCK=1, lock SHALL have no effect.
REQ-022 The requester just released SHALL take part in the same-edge re-arbitration at lowest round-robin priority.
REQ-023 lock bits of requesters that are not granted SHALL be ignored.
REQ-024 q SHALL hold its value on every edge without a write.

Reset
REQ-025 While rst_n=0: state=IDLE, gnt=0, owner=0, rr_ptr=0, lock_cnt=0, q=0, q_valid=0, taking effect immediately without waiting for clk.
REQ-026 Reset asserted mid-grant SHALL abort the grant; no write SHALL occur at or after the reset edge.
REQ-027 The first arbitration after deassert SHALL occur at the first rising clk edge with rst_n=1.

Configuration
REQ-028 Macro REG_WR_ARB_PRIO0_EN, when defined: requester 0 SHALL win every arbitration in which req[0]=1, regardless of rr_ptr.
REQ-029 With REG_WR_ARB_PRIO0_EN defined, requester 0 SHALL NOT preempt a current owner; rr_ptr still updates per REQ-018.
REQ-030 Without REG_WR_ARB_PRIO0_EN: pure round-robin per REQ-015 for all requesters.

Verification
REQ-031 Reset: rst_n=0 mid-grant with q=0xA5 -> q=0x00, gnt=0, q_valid=0 immediately; after release, req=0001 -> gnt=0001 on the next edge.
REQ-032 Round-robin: req=1111 held, lock=0 -> gnt sequence 0001,0010,0100,1000,0001 with no idle cycles; q takes each wdata slice in turn, q_valid high continuously from the second cycle.
REQ-033 Lock limit: MAX_LOCK=4, req=0011, lock=0001 -> requester 0 writes 4 consecutive cycles, then gnt=0010.
REQ-034 Drop: granted requester 2 deasserts req -> no write, q unchanged, q_valid=0, grant moves to the next pending requester or IDLE.
REQ-035 Wrap: rr_ptr=3, req=1001 -> requester 3 wins, then requester 0; with REG_WR_ARB_PRIO0_EN defined, requester 0 wins first.

Source files
------------

// File: rtl/reg_wr_arb.sv
// Shared-register write arbiter: round-robin grant with bounded lock, one write per granted cycle.
// Latency: grant one edge after request; q/q_valid registered one cycle after each write edge.
// Backpressure: requesters hold req until granted; optional REG_WR_ARB_PRIO0_EN gives requester 0 fixed priority.
module reg_wr_arb #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_LOCK = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ*DATA_W-1:0]     wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic [DATA_W-1:0]             q,
    output logic                          q_valid
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = 5;

    typedef enum logic {IDLE, OWN} state_t;

    state_t              state_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [OW-1:0]       owner_q;
    logic [OW-1:0]       rr_ptr_q;
    logic [CW-1:0]       lock_cnt_q;
    logic [DATA_W-1:0]   q_q;
    logic                q_valid_q;

    logic [OW-1:0]       nxt_ptr_d;
    logic [OW-1:0]       base_d;
    logic [OW-1:0]       win_idx_d;
    logic                win_vld_d;
    logic                wr_en_d;
    logic                stay_d;

    // (b + off) mod NUM_REQ without a divider; both operands are below NUM_REQ
    function automatic logic [OW-1:0] rr_idx(input logic [OW-1:0] b, input int off);
        logic [OW:0] s;
        s = {1'b0, b} + (OW+1)'(off);
        if (s >= (OW+1)'(NUM_REQ)) begin
            s = s - (OW+1)'(NUM_REQ);
        end
        return s[OW-1:0];
    endfunction

    // Write/hold decision for the owner, and the winner of this edge's arbitration.
    // On release the scan starts just past the owner, so the owner ranks last.
    always_comb begin
        nxt_ptr_d = (owner_q == OW'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
        wr_en_d   = (state_q == OWN) && req[owner_q];
        stay_d    = wr_en_d && lock[owner_q] && (lock_cnt_q < CW'(MAX_LOCK-1));
        base_d    = (state_q == OWN) ? nxt_ptr_d : rr_ptr_q;
        win_vld_d = 1'b0;
        win_idx_d = base_d;
        // scan downward so the lowest offset from base_d is the one that sticks
        for (int i = NUM_REQ-1; i >= 0; i--) begin
            if (req[rr_idx(base_d, i)]) begin
                win_vld_d = 1'b1;
                win_idx_d = rr_idx(base_d, i);
            end
        end
`ifdef REG_WR_ARB_PRIO0_EN
        if (req[0]) begin
            win_vld_d = 1'b1;
            win_idx_d = '0;
        end
`endif
    end

    // Arbiter FSM with registered grant, owner, lock counter and shared register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            lock_cnt_q <= '0;
            q_q        <= '0;
            q_valid_q  <= 1'b0;
        end else begin
            q_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_vld_d) begin
                        state_q    <= OWN;
                        gnt_q      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_d;
                        owner_q    <= win_idx_d;
                        lock_cnt_q <= '0;
                    end
                end
                OWN: begin
                    if (wr_en_d) begin
                        q_q       <= wdata[int'(owner_q)*DATA_W +: DATA_W];
                        q_valid_q <= 1'b1;
                    end
                    if (stay_d) begin
                        lock_cnt_q <= lock_cnt_q + 1'b1;
                    end else begin
                        rr_ptr_q   <= nxt_ptr_d;
                        lock_cnt_q <= '0;
                        if (win_vld_d) begin
                            gnt_q   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_d;
                            owner_q <= win_idx_d;
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign owner   = owner_q;
    assign q       = q_q;
    assign q_valid = q_valid_q;

endmodule
